// File: rtl/tl_pkg.sv
// Shared TX transaction-layer types: stream beat, class selector and the
// Fmt/Type -> ordering-class decode used by the TX class router.
package tl_pkg;

  localparam int unsigned TL_DATA_W = 32;

  typedef struct packed {
    logic [TL_DATA_W-1:0] data;
    logic                 sop;
    logic                 eop;
  } tl_stream_t;

  typedef enum logic [1:0] {
    POSTED = 2'd0,
    NP     = 2'd1,
    CPL    = 2'd2,
    NONE   = 2'd3
  } queue_sel_e;

  localparam logic [4:0] TLP_TYPE_MEM     = 5'b00000;
  localparam logic [4:0] TLP_TYPE_CFG0    = 5'b00100;
  localparam logic [4:0] TLP_TYPE_CPL     = 5'b01010;
  localparam logic [1:0] TLP_TYPE_MSG_PFX = 2'b10;

  // CfgWr stays Non-Posted and all messages are Posted.
  function automatic queue_sel_e tl_decode_class(input logic [2:0] fmt,
                                                 input logic [4:0] tlp_type);
    queue_sel_e cls;
    cls = NONE;
    if (tlp_type == TLP_TYPE_MEM)               cls = fmt[1] ? POSTED : NP;
    else if (tlp_type == TLP_TYPE_CFG0)         cls = NP;
    else if (tlp_type == TLP_TYPE_CPL)          cls = CPL;
    else if (tlp_type[4:3] == TLP_TYPE_MSG_PFX) cls = POSTED;
    return cls;
  endfunction

endpackage

// File: rtl/tl_stream_fifo.sv
// Small per-class beat FIFO; wrap-bit pointers give full/empty without a counter.
module tl_stream_fifo
  import tl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  tl_stream_t din,
  input  logic       push,
  output logic       full,
  output tl_stream_t dout,
  output logic       valid,
  input  logic       ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tl_stream_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    valid   = (wr_ptr != rd_ptr);
    dout    = mem[rd_ptr[AW-1:0]];
    do_push = push & ~full;
    do_pop  = valid & ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tl_tx_class_router.sv
// Steers whole TX packets to Posted / Non-Posted / Completion queues,
// drops unsupported and orphan traffic, and keeps per-class packet counts.
module tl_tx_class_router
  import tl_pkg::*;
#(
  parameter int unsigned BUF_DEPTH        = 2,
  parameter int unsigned CNT_W            = 16,
  parameter bit          DROP_UNSUPPORTED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  tl_stream_t       pkt_i,
  input  logic             pkt_valid_i,
  output logic             pkt_ready_o,
  output tl_stream_t       pkt_posted_o,
  output tl_stream_t       pkt_np_o,
  output tl_stream_t       pkt_cpl_o,
  output logic             pkt_posted_valid_o,
  output logic             pkt_np_valid_o,
  output logic             pkt_cpl_valid_o,
  input  logic             pkt_posted_ready_i,
  input  logic             pkt_np_ready_i,
  input  logic             pkt_cpl_ready_i,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] cnt_posted_o,
  output logic [CNT_W-1:0] cnt_np_o,
  output logic [CNT_W-1:0] cnt_cpl_o,
  output logic [CNT_W-1:0] cnt_drop_o,
  output logic             err_unsup_o,
  output logic             err_proto_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ROUTE, ST_DROP} rtr_state_e;

  rtr_state_e       state, state_nxt;
  queue_sel_e       lock_cls, lock_cls_nxt;
  queue_sel_e       dec_cls, sop_cls, target;
  logic             orphan, accept;
  logic [2:0]       push, full;
  logic [3:0]       inc;
  logic [CNT_W-1:0] cnt [4];
  logic             err_unsup_q, err_proto_q;

  always_comb begin
    dec_cls = tl_decode_class(pkt_i.data[7:5], pkt_i.data[4:0]);
    sop_cls = (dec_cls == NONE && !DROP_UNSUPPORTED) ? POSTED : dec_cls;
    orphan  = 1'b0;
    target  = NONE;
    if (pkt_i.sop)               target = sop_cls;
    else if (state == ST_ROUTE)  target = lock_cls;
    else if (state == ST_IDLE)   orphan = 1'b1;

    // Ready looks only at the target's full flag, never at the class pop.
    case (target)
      POSTED:  pkt_ready_o = ~full[0];
      NP:      pkt_ready_o = ~full[1];
      CPL:     pkt_ready_o = ~full[2];
      default: pkt_ready_o = 1'b1;
    endcase
    accept = pkt_valid_i & pkt_ready_o;

    push = '0;
    inc  = '0;
    if (accept) begin
      case (target)
        POSTED:  begin push[0] = 1'b1; inc[0] = pkt_i.eop; end
        NP:      begin push[1] = 1'b1; inc[1] = pkt_i.eop; end
        CPL:     begin push[2] = 1'b1; inc[2] = pkt_i.eop; end
        default: inc[3] = pkt_i.eop | orphan;
      endcase
    end

    state_nxt    = state;
    lock_cls_nxt = lock_cls;
    if (accept) begin
      if (pkt_i.sop) begin
        lock_cls_nxt = sop_cls;
        if (pkt_i.eop)             state_nxt = ST_IDLE;
        else if (sop_cls == NONE)  state_nxt = ST_DROP;
        else                       state_nxt = ST_ROUTE;
      end else if (pkt_i.eop) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lock_cls    <= NONE;
      err_unsup_q <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      lock_cls    <= lock_cls_nxt;
      err_unsup_q <= accept & pkt_i.sop & (dec_cls == NONE);
      err_proto_q <= accept & (orphan | (pkt_i.sop & (state != ST_IDLE)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (clr_cnt_i)                     cnt[i] <= '0;
        else if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign cnt_posted_o = cnt[0];
  assign cnt_np_o     = cnt[1];
  assign cnt_cpl_o    = cnt[2];
  assign cnt_drop_o   = cnt[3];
  assign err_unsup_o  = err_unsup_q;
  assign err_proto_o  = err_proto_q;

  tl_stream_fifo #(.DEPTH(BUF_DEPTH)) u_fifo_posted (
    .clk(clk), .rst_n(rst_n), .din(pkt_i), .push(push[0]), .full(full[0]),
    .dout(pkt_posted_o), .valid(pkt_posted_valid_o), .ready(pkt_posted_ready_i)
  );

  tl_stream_fifo #(.DEPTH(BUF_DEPTH)) u_fifo_np (
    .clk(clk), .rst_n(rst_n), .din(pkt_i), .push(push[1]), .full(full[1]),
    .dout(pkt_np_o), .valid(pkt_np_valid_o), .ready(pkt_np_ready_i)
  );

  tl_stream_fifo #(.DEPTH(BUF_DEPTH)) u_fifo_cpl (
    .clk(clk), .rst_n(rst_n), .din(pkt_i), .push(push[2]), .full(full[2]),
    .dout(pkt_cpl_o), .valid(pkt_cpl_valid_o), .ready(pkt_cpl_ready_i)
  );

endmodule

// File: doc/tl_tx_class_router.md
Name: tl_tx_class_router

Overview:
Parametrised successor TX packet router between payload_mux and the per-class TX queues (Posted / Non-Posted / Completion).
- Decodes Fmt/Type on SOP beats and steers the whole packet to one class.
- Buffers each class in its own small FIFO, which breaks the ready path.
- Drops unsupported or orphan packets cleanly and keeps per-class statistics.
- Uses PCIe-correct ordering classes: CfgWr is Non-Posted, and messages are Posted.

Parameters:
BUF_DEPTH, 2, entries per class output FIFO; power of two, ≥2.
CNT_W, 16, width of each saturating statistics counter.
DROP_UNSUPPORTED, 1, 1 = unsupported SOP types are consumed and discarded; 0 = they are routed to the Posted class.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pkt_i  in  tl_stream_t  input beat; uses data, sop, eop
pkt_valid_i  in  1  input valid
pkt_ready_o  out  1  input ready
pkt_posted_o / pkt_np_o / pkt_cpl_o  out  tl_stream_t  class output beats
pkt_posted_valid_o / pkt_np_valid_o / pkt_cpl_valid_o  out  1  class valids
pkt_posted_ready_i / pkt_np_ready_i / pkt_cpl_ready_i  in  1  class readies
clr_cnt_i  in  1  synchronous clear of all counters
cnt_posted_o / cnt_np_o / cnt_cpl_o  out  CNT_W  packets forwarded per class (counted at EOP)
cnt_drop_o  out  CNT_W  packets dropped
err_unsup_o  out  1  one-cycle pulse when an unsupported SOP is accepted
err_proto_o  out  1  one-cycle pulse on an orphan beat or on SOP-inside-packet

Behaviour:
Reset (async assert, sync release):
- all FIFOs empty; all valids 0; state IDLE; counters 0; err pulses 0.
- beat outputs are don't-care while valid is 0.

Decode (SOP beats only), with fmt = data[7:5] and type = data[4:0]:
- Posted: MWr (fmt[1]=1, type 00000); Msg/MsgD (type[4:3]=10).
- Non-Posted: MRd (fmt[1]=0, type 00000); CfgRd and CfgWr (type 00100, either fmt[1]).
- Completion: Cpl/CplD (type 01010).
- Anything else is unsupported.

State machine (states IDLE, ROUTE(cls), DROP):
- IDLE, SOP&eop accepted: single-beat packet; written to its class; stay IDLE.
- IDLE, SOP without eop accepted: go to ROUTE(cls), or to DROP if unsupported and DROP_UNSUPPORTED=1.
- IDLE, non-SOP beat: orphan. Consume it (ready=1), discard it, pulse err_proto_o, increment cnt_drop_o.
- ROUTE: subsequent beats go to the locked class. An accepted eop returns to IDLE.
- ROUTE, SOP beat arrives: pulse err_proto_o, re-decode, and the beat starts a new packet. The previous packet is not counted.
- DROP: ready=1, beats discarded. eop returns to IDLE and increments cnt_drop_o once per packet.
- An unsupported SOP accepted from IDLE pulses err_unsup_o on the cycle after acceptance.

Handshake and FIFOs:
- pkt_ready_o = not-full of the target FIFO (combinational on SOP decode, or on the locked class); 1 in DROP or for orphans.
- Transfer happens when valid & ready. pkt_valid_i must not depend on pkt_ready_o.
- Class output valid = FIFO not empty; a pop occurs on valid & ready.
- Latency: a beat accepted in cycle N is visible at the class output in N+1 (empty FIFO).
- Full FIFO: ready=0; the beat is held and the state does not advance.
- Simultaneous push and pop on a full FIFO: the push is still refused. Ready does not look at the pop, so there is no comb path from class ready to pkt_ready_o.
- Pointers are log2(BUF_DEPTH)+1 bits, with wrap bit for full/empty.
- Order is preserved within a class. Classes are independent, so a blocked class never stalls another class's FIFO draining.

Counters:
- Increment on accepted eop in ROUTE/IDLE for the class (and in DROP for cnt_drop_o).
- Saturate at all-ones.
- clr_cnt_i has priority over an increment in the same cycle.

Decomposition:
- tl_pkg gains: queue_sel_e (POSTED, NP, CPL, NONE); TLP_TYPE_MEM=5'b00000, TLP_TYPE_CFG0=5'b00100, TLP_TYPE_CPL=5'b01010; MSG type prefix 2'b10; function tl_decode_class(fmt, type) returning queue_sel_e.
- One sub-module: tl_stream_fifo (parametrised on depth, tl_stream_t payload), instantiated three times.

Test Plan:
1. Three-beat MWr (data[7:0]=8'h40), all readies 1 → 3 beats on posted in order, 1-cycle latency; cnt_posted_o=1, cnt_np_o=0, cnt_cpl_o=0.
2. Single-beat CfgWr (8'h44, sop=eop=1) → appears on np only; cnt_np_o=1; IDLE retained.
3. pkt_np_ready_i=0, BUF_DEPTH=2, three 1-beat MRd → 2 accepted, pkt_ready_o=0 on the third. Concurrently a CplD (8'h4A) can still be sent after ready is released, and it drains on cpl.
4. Unsupported type 5'b11111 with 4 beats, DROP_UNSUPPORTED=1 → no output valids; err_unsup_o pulses once; cnt_drop_o=1; ready=1 on all beats.
5. Orphan beat (sop=0) in IDLE, then SOP mid-ROUTE → err_proto_o pulses on both events; cnt_drop_o=1; the new packet routes correctly.
6. Counter saturation with CNT_W=4 after 17 posted packets → cnt_posted_o=15. clr_cnt_i together with an EOP → 0. rst_n asserted mid-packet → FIFOs empty, state IDLE, next SOP routed normally.
